// File: rtl/soc_bus_arbiter_if.sv
// Bundle of the two master request/response ports and the shared interconnect bus.
// master: arbiter side; slave: the masters and interconnect facing the arbiter.
interface soc_bus_arbiter_if #(
    parameter int unsigned AW = 19,
    parameter int unsigned DW = 19
);
    logic          m0_valid;
    logic          m0_write;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_lock;
    logic          m0_ready;
    logic [DW-1:0] m0_rdata;

    logic          m1_valid;
    logic          m1_write;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_lock;
    logic          m1_ready;
    logic [DW-1:0] m1_rdata;

    logic          bus_valid;
    logic          bus_write;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          grant_id;
    logic          busy;

    modport master (
        input  m0_valid, m0_write, m0_addr, m0_wdata, m0_lock,
        output m0_ready, m0_rdata,
        input  m1_valid, m1_write, m1_addr, m1_wdata, m1_lock,
        output m1_ready, m1_rdata,
        output bus_valid, bus_write, bus_addr, bus_wdata,
        input  bus_rdata,
        output grant_id, busy
    );

    modport slave (
        output m0_valid, m0_write, m0_addr, m0_wdata, m0_lock,
        input  m0_ready, m0_rdata,
        output m1_valid, m1_write, m1_addr, m1_wdata, m1_lock,
        input  m1_ready, m1_rdata,
        input  bus_valid, bus_write, bus_addr, bus_wdata,
        output bus_rdata,
        input  grant_id, busy
    );
endinterface

// File: rtl/soc_bus_arbiter.sv
// Two-master round-robin arbiter with locked bursts, programmable access time and
// registered read-data return in front of the SoC address-decode interconnect.
module soc_bus_arbiter #(
    parameter int unsigned AW          = 19,
    parameter int unsigned DW          = 19,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned MAX_BURST   = 4
) (
    input logic               clk,
    input logic               rst_n,
    soc_bus_arbiter_if.master bif
);
    localparam int unsigned   WCW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int unsigned   BCW        = $clog2(MAX_BURST + 1);
    localparam logic [WCW-1:0] WCNT_LOAD  = WCW'(WAIT_CYCLES - 1);
    localparam logic [BCW-1:0] BURST_LAST = BCW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [BCW-1:0] burst_cnt_q, burst_cnt_d;
    logic           lock_act_q, lock_act_d;
    logic           lock_owner_q, lock_owner_d;
    logic           last_id_q, last_id_d;
    logic           grant_id_q, grant_id_d;
    logic           bus_valid_q, bus_valid_d;
    logic           bus_write_q, bus_write_d;
    logic [AW-1:0]  bus_addr_q, bus_addr_d;
    logic [DW-1:0]  bus_wdata_q, bus_wdata_d;
    logic           m0_ready_q, m0_ready_d;
    logic           m1_ready_q, m1_ready_d;
    logic [DW-1:0]  m0_rdata_q, m0_rdata_d;
    logic [DW-1:0]  m1_rdata_q, m1_rdata_d;
    logic           busy_q, busy_d;

    logic           take;
    logic           sel_id;
    logic           owner_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            wcnt_q       <= '0;
            burst_cnt_q  <= '0;
            lock_act_q   <= 1'b0;
            lock_owner_q <= 1'b0;
            last_id_q    <= 1'b1;
            grant_id_q   <= 1'b0;
            bus_valid_q  <= 1'b0;
            bus_write_q  <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wcnt_q       <= wcnt_d;
            burst_cnt_q  <= burst_cnt_d;
            lock_act_q   <= lock_act_d;
            lock_owner_q <= lock_owner_d;
            last_id_q    <= last_id_d;
            grant_id_q   <= grant_id_d;
            bus_valid_q  <= bus_valid_d;
            bus_write_q  <= bus_write_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wcnt_d       = wcnt_q;
        burst_cnt_d  = burst_cnt_q;
        lock_act_d   = lock_act_q;
        lock_owner_d = lock_owner_q;
        last_id_d    = last_id_q;
        grant_id_d   = grant_id_q;
        bus_valid_d  = bus_valid_q;
        bus_write_d  = bus_write_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        m0_rdata_d   = m0_rdata_q;
        m1_rdata_d   = m1_rdata_q;
        take         = 1'b0;
        sel_id       = 1'b0;
        owner_valid  = lock_owner_q ? bif.m1_valid : bif.m0_valid;

        unique case (state_q)
            IDLE: begin
                // A lock only survives while its owner keeps requesting and has burst budget left.
                if (lock_act_q && owner_valid && (burst_cnt_q < BURST_LAST)) begin
                    take        = 1'b1;
                    sel_id      = lock_owner_q;
                    burst_cnt_d = burst_cnt_q + BCW'(1);
                end else begin
                    lock_act_d  = 1'b0;
                    burst_cnt_d = '0;
                    if (bif.m0_valid && bif.m1_valid) begin
                        take   = 1'b1;
                        sel_id = ~last_id_q;
                    end else if (bif.m0_valid) begin
                        take   = 1'b1;
                        sel_id = 1'b0;
                    end else if (bif.m1_valid) begin
                        take   = 1'b1;
                        sel_id = 1'b1;
                    end
                end
                if (take) begin
                    grant_id_d  = sel_id;
                    bus_write_d = sel_id ? bif.m1_write : bif.m0_write;
                    bus_addr_d  = sel_id ? bif.m1_addr  : bif.m0_addr;
                    bus_wdata_d = sel_id ? bif.m1_wdata : bif.m0_wdata;
                    bus_valid_d = 1'b1;
                    wcnt_d      = WCNT_LOAD;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - WCW'(1);
                end else begin
                    bus_valid_d = 1'b0;
                    state_d     = RESP;
                    if (grant_id_q) begin
                        m1_ready_d = 1'b1;
                        if (!bus_write_q) m1_rdata_d = bif.bus_rdata;
                    end else begin
                        m0_ready_d = 1'b1;
                        if (!bus_write_q) m0_rdata_d = bif.bus_rdata;
                    end
                end
            end
            RESP: begin
                last_id_d    = grant_id_q;
                lock_act_d   = grant_id_q ? bif.m1_lock : bif.m0_lock;
                lock_owner_d = grant_id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign bif.bus_valid = bus_valid_q;
    assign bif.bus_write = bus_write_q;
    assign bif.bus_addr  = bus_addr_q;
    assign bif.bus_wdata = bus_wdata_q;
    assign bif.m0_ready  = m0_ready_q;
    assign bif.m1_ready  = m1_ready_q;
    assign bif.m0_rdata  = m0_rdata_q;
    assign bif.m1_rdata  = m1_rdata_q;
    assign bif.grant_id  = grant_id_q;
    assign bif.busy      = busy_q;
endmodule

// File: tb/tb_soc_bus_arbiter.sv
// Bench for soc_bus_arbiter: a WAIT_CYCLES=1 instance tracked cycle by cycle against a
// transaction-level reference model, and a WAIT_CYCLES=3 instance driven with directed cases.
module tb_soc_bus_arbiter;
    localparam int unsigned AW = 19;
    localparam int unsigned DW = 19;
    localparam int unsigned WA = 1;
    localparam int unsigned MB = 4;

    logic clk     = 1'b0;
    logic rst_n_a = 1'b0;
    logic rst_n_b = 1'b0;
    logic mon_a   = 1'b1;

    always #5 clk = ~clk;

    soc_bus_arbiter_if #(.AW(AW), .DW(DW)) ifa ();
    soc_bus_arbiter_if #(.AW(AW), .DW(DW)) ifb ();

    soc_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(WA), .MAX_BURST(MB)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .bif(ifa.master));
    soc_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(3), .MAX_BURST(MB)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .bif(ifb.master));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: occupancy counts the busy cycles left in the current access,
    // streak counts consecutive grants held by the lock owner.
    int            occ, cur_m, last_m, lock_owner, streak, g;
    logic          e_valid, e_write, e_grant, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [1:0]    e_ready;
    logic [DW-1:0] e_rdata [2];

    function automatic logic req_valid(input int m);
        return (m == 1) ? ifa.m1_valid : ifa.m0_valid;
    endfunction

    function automatic logic req_lock(input int m);
        return (m == 1) ? ifa.m1_lock : ifa.m0_lock;
    endfunction

    task model_reset;
        occ = 0; cur_m = 0; last_m = 1; lock_owner = -1; streak = 0; g = -1;
        e_valid = 1'b0; e_write = 1'b0; e_grant = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_wdata = '0; e_ready = '0;
        e_rdata[0] = '0; e_rdata[1] = '0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n_a);
            if (!rst_n_a) begin
                model_reset();
            end else if (occ == 0) begin
                g = -1;
                if (lock_owner >= 0 && req_valid(lock_owner) && streak < int'(MB)) begin
                    g = lock_owner;
                    streak++;
                end else begin
                    lock_owner = -1;
                    streak     = 0;
                    if (req_valid(0) && req_valid(1)) g = 1 - last_m;
                    else if (req_valid(0))            g = 0;
                    else if (req_valid(1))            g = 1;
                    if (g >= 0) streak = 1;
                end
                if (g >= 0) begin
                    cur_m   = g;
                    e_grant = (g == 1);
                    e_write = (g == 1) ? ifa.m1_write : ifa.m0_write;
                    e_addr  = (g == 1) ? ifa.m1_addr  : ifa.m0_addr;
                    e_wdata = (g == 1) ? ifa.m1_wdata : ifa.m0_wdata;
                    e_valid = 1'b1;
                    e_busy  = 1'b1;
                    occ     = int'(WA) + 1;
                end
            end else if (occ > 1) begin
                occ--;
                if (occ == 1) begin
                    e_valid = 1'b0;
                    e_ready[cur_m] = 1'b1;
                    if (!e_write) e_rdata[cur_m] = ifa.bus_rdata;
                end
            end else begin
                occ        = 0;
                e_ready    = '0;
                e_busy     = 1'b0;
                last_m     = cur_m;
                lock_owner = req_lock(cur_m) ? cur_m : -1;
            end
        end
    end

    always @(negedge clk) begin
        if (mon_a) begin
            check_eq("a_bus_valid", 32'(ifa.bus_valid), 32'(e_valid));
            check_eq("a_bus_write", 32'(ifa.bus_write), 32'(e_write));
            check_eq("a_bus_addr",  32'(ifa.bus_addr),  32'(e_addr));
            check_eq("a_bus_wdata", 32'(ifa.bus_wdata), 32'(e_wdata));
            check_eq("a_m0_ready",  32'(ifa.m0_ready),  32'(e_ready[0]));
            check_eq("a_m1_ready",  32'(ifa.m1_ready),  32'(e_ready[1]));
            check_eq("a_m0_rdata",  32'(ifa.m0_rdata),  32'(e_rdata[0]));
            check_eq("a_m1_rdata",  32'(ifa.m1_rdata),  32'(e_rdata[1]));
            check_eq("a_grant_id",  32'(ifa.grant_id),  32'(e_grant));
            check_eq("a_busy",      32'(ifa.busy),      32'(e_busy));
        end
    end

    task automatic set_a(input int m, input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic lk);
        if (m == 0) begin
            ifa.m0_valid = v; ifa.m0_write = w; ifa.m0_addr = a; ifa.m0_wdata = d; ifa.m0_lock = lk;
        end else begin
            ifa.m1_valid = v; ifa.m1_write = w; ifa.m1_addr = a; ifa.m1_wdata = d; ifa.m1_lock = lk;
        end
    endtask

    task automatic rand_req_a(input int m);
        set_a(m, 1'b1, 1'($urandom), {3'($urandom_range(0, 7)), 16'($urandom)},
              DW'($urandom), 1'($urandom));
    endtask

    task automatic pulse_reset_a();
        @(negedge clk); #2 rst_n_a = 1'b0;
        @(negedge clk); #2 rst_n_a = 1'b1;
    endtask

    task automatic wait_ready_a(input int m, input int budget);
        bit seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (e_ready[m]) seen = 1'b1;
        end
        check_eq("a_ready_wait", 32'(seen), 32'd1);
    endtask

    int            k;
    bit            pend [2];
    logic [5:0]    lk_pat;
    logic [DW-1:0] rdv [3];

    initial begin
        set_a(0, 1'b0, 1'b0, '0, '0, 1'b0);
        set_a(1, 1'b0, 1'b0, '0, '0, 1'b0);
        ifa.bus_rdata = '0;
        ifb.m0_valid = 1'b0; ifb.m0_write = 1'b0; ifb.m0_addr = '0; ifb.m0_wdata = '0; ifb.m0_lock = 1'b0;
        ifb.m1_valid = 1'b0; ifb.m1_write = 1'b0; ifb.m1_addr = '0; ifb.m1_wdata = '0; ifb.m1_lock = 1'b0;
        ifb.bus_rdata = '0;

        repeat (2) @(negedge clk);
        check_eq("b_rst_bus_valid", 32'(ifb.bus_valid), 32'd0);
        check_eq("b_rst_busy",      32'(ifb.busy),      32'd0);
        check_eq("b_rst_grant",     32'(ifb.grant_id),  32'd0);
        check_eq("b_rst_ready",     32'({ifb.m0_ready, ifb.m1_ready}), 32'd0);
        check_eq("b_rst_addr",      32'(ifb.bus_addr),  32'd0);
        #2 rst_n_a = 1'b1; rst_n_b = 1'b1;

        // Single read with WAIT_CYCLES=1.
        @(negedge clk);
        ifa.bus_rdata = 19'h01234;
        set_a(0, 1'b1, 1'b0, 19'h70010, '0, 1'b0);
        @(negedge clk);
        check_eq("a_t1_valid", 32'(ifa.bus_valid), 32'd1);
        check_eq("a_t1_addr",  32'(ifa.bus_addr),  32'h70010);
        @(negedge clk);
        check_eq("a_t1_ready", 32'(ifa.m0_ready),  32'd1);
        check_eq("a_t1_rdata", 32'(ifa.m0_rdata),  32'h01234);
        check_eq("a_t1_vdrop", 32'(ifa.bus_valid), 32'd0);
        ifa.m0_valid = 1'b0;
        @(negedge clk);
        check_eq("a_t1_pulse", 32'(ifa.m0_ready),  32'd0);

        // Both masters hold requests after reset: grants alternate starting with m0.
        pulse_reset_a();
        @(negedge clk);
        set_a(0, 1'b1, 1'b0, 19'h10000, '0, 1'b0);
        set_a(1, 1'b1, 1'b0, 19'h20000, '0, 1'b0);
        k = 0;
        for (int c = 0; c < 40 && k < 4; c++) begin
            @(negedge clk);
            if (ifa.m0_ready || ifa.m1_ready) begin
                check_eq("a_rr_grant", 32'(ifa.grant_id), 32'(k % 2));
                k++;
            end
        end
        check_eq("a_rr_count", 32'(k), 32'd4);
        ifa.m0_valid = 1'b0; ifa.m1_valid = 1'b0;
        repeat (6) @(negedge clk);

        // Locked m0 burst against a waiting m1: four m0 grants, one m1, then m0 again.
        pulse_reset_a();
        @(negedge clk);
        lk_pat = 6'b010000;
        set_a(0, 1'b1, 1'b0, 19'h30000, '0, 1'b1);
        set_a(1, 1'b1, 1'b0, 19'h40000, '0, 1'b0);
        k = 0;
        for (int c = 0; c < 60 && k < 6; c++) begin
            @(negedge clk);
            if (ifa.m0_ready || ifa.m1_ready) begin
                check_eq("a_lock_grant", 32'(ifa.grant_id), 32'(lk_pat[k]));
                k++;
            end
        end
        check_eq("a_lock_count", 32'(k), 32'd6);
        ifa.m0_valid = 1'b0; ifa.m1_valid = 1'b0; ifa.m0_lock = 1'b0;
        repeat (8) @(negedge clk);

        // m1 read then write: the write must leave m1_rdata untouched.
        ifa.bus_rdata = 19'h11111;
        set_a(1, 1'b1, 1'b0, 19'h00040, '0, 1'b0);
        wait_ready_a(1, 10);
        set_a(1, 1'b1, 1'b1, 19'h60004, 19'h5A5A5, 1'b0);
        ifa.bus_rdata = 19'h22222;
        repeat (2) @(negedge clk);
        check_eq("a_wr_valid", 32'(ifa.bus_valid), 32'd1);
        check_eq("a_wr_write", 32'(ifa.bus_write), 32'd1);
        check_eq("a_wr_addr",  32'(ifa.bus_addr),  32'h60004);
        check_eq("a_wr_wdata", 32'(ifa.bus_wdata), 32'h5A5A5);
        @(negedge clk);
        check_eq("a_wr_ready", 32'(ifa.m1_ready),  32'd1);
        check_eq("a_wr_m0rdy", 32'(ifa.m0_ready),  32'd0);
        check_eq("a_wr_rdata", 32'(ifa.m1_rdata),  32'h11111);
        ifa.m1_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Random traffic: masters hold each request until its ready, then may chain another.
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            ifa.bus_rdata = DW'($urandom);
            for (int m = 0; m < 2; m++) begin
                if (pend[m] && e_ready[m]) begin
                    pend[m] = 1'b0;
                    if ($urandom_range(0, 1) == 0) begin
                        rand_req_a(m);
                        pend[m] = 1'b1;
                    end else begin
                        set_a(m, 1'b0, 1'b0, '0, '0, 1'b0);
                    end
                end else if (pend[m]) begin
                    if ($urandom_range(0, 7) == 0) rand_req_a(m);
                    if ($urandom_range(0, 3) == 0) begin
                        if (m == 0) ifa.m0_lock = ~ifa.m0_lock;
                        else        ifa.m1_lock = ~ifa.m1_lock;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    rand_req_a(m);
                    pend[m] = 1'b1;
                end
            end
        end
        for (int m = 0; m < 2; m++) begin
            if (pend[m]) wait_ready_a(m, 20);
            set_a(m, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        repeat (4) @(negedge clk);

        // WAIT_CYCLES=3 read: bus_valid for three cycles, data taken from the third.
        rdv[0] = 19'h00111; rdv[1] = 19'h00222; rdv[2] = 19'h00333;
        @(negedge clk);
        ifb.m0_valid = 1'b1; ifb.m0_write = 1'b0; ifb.m0_addr = 19'h70020;
        ifb.bus_rdata = 19'h0AAAA;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("b_w3_valid", 32'(ifb.bus_valid), 32'd1);
            check_eq("b_w3_noready", 32'(ifb.m0_ready), 32'd0);
            ifb.bus_rdata = rdv[i];
        end
        @(negedge clk);
        check_eq("b_w3_vdrop", 32'(ifb.bus_valid), 32'd0);
        check_eq("b_w3_ready", 32'(ifb.m0_ready),  32'd1);
        check_eq("b_w3_rdata", 32'(ifb.m0_rdata),  32'h00333);
        check_eq("b_w3_busy",  32'(ifb.busy),      32'd1);
        ifb.m0_valid = 1'b0;
        @(negedge clk);
        check_eq("b_w3_pulse", 32'(ifb.m0_ready),  32'd0);
        check_eq("b_w3_idle",  32'(ifb.busy),      32'd0);

        // Asynchronous reset in the second access cycle abandons the transfer.
        @(negedge clk);
        ifb.m0_valid = 1'b1; ifb.m0_addr = 19'h70030;
        repeat (2) @(negedge clk);
        check_eq("b_rst_mid_valid", 32'(ifb.bus_valid), 32'd1);
        rst_n_b = 1'b0;
        #1;
        check_eq("b_rst_async_valid", 32'(ifb.bus_valid), 32'd0);
        check_eq("b_rst_async_busy",  32'(ifb.busy),      32'd0);
        ifb.m0_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_eq("b_rst_no_ready", 32'({ifb.m0_ready, ifb.m1_ready}), 32'd0);
        end
        rst_n_b = 1'b1;
        ifb.m1_valid = 1'b1; ifb.m1_write = 1'b1; ifb.m1_addr = 19'h60008; ifb.m1_wdata = 19'h12345;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("b_post_valid", 32'(ifb.bus_valid), 32'd1);
            check_eq("b_post_grant", 32'(ifb.grant_id),  32'd1);
        end
        @(negedge clk);
        check_eq("b_post_ready", 32'(ifb.m1_ready),  32'd1);
        check_eq("b_post_m0rdy", 32'(ifb.m0_ready),  32'd0);
        check_eq("b_post_write", 32'(ifb.bus_write), 32'd1);
        check_eq("b_post_addr",  32'(ifb.bus_addr),  32'h60008);
        check_eq("b_post_wdata", 32'(ifb.bus_wdata), 32'h12345);
        check_eq("b_post_rdata", 32'(ifb.m1_rdata),  32'd0);
        ifb.m1_valid = 1'b0;
        @(negedge clk);
        check_eq("b_post_pulse", 32'(ifb.m1_ready),  32'd0);

        mon_a = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
